// File: rtl/mul_div_pkg.sv
// Shared definitions for the multiply/divide datapath: width defaults,
// divider FSM states and the iteration counter width.
package mul_div_pkg;

    localparam int DW_DEF = 16;          // operand / quotient width
    localparam int PW_DEF = 2 * DW_DEF;  // dividend (product) width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Counter must be able to hold 0..DW.
    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

    localparam int CNT_W = $clog2(DW_DEF + 1);

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step. The partial remainder is kept one bit
// wider than the divisor so that the shifted value (< 2*d) never overflows.
module div_step
    import mul_div_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW:0]   rem_in,
    input  logic          bit_in,
    input  logic [DW-1:0] d,
    output logic [DW:0]   rem_out,
    output logic          q_bit
);

    logic [DW+1:0] wide;
    logic [DW:0]   diff;

    // Shift in the next dividend bit, trial-subtract, restore if negative.
    // The top bit of wide is folded into the compare; the subtraction only
    // needs DW+1 bits because the true result is always below 2^DW.
    always_comb begin
        wide    = {rem_in, bit_in};
        q_bit   = wide[DW+1] | (wide[DW:0] >= {1'b0, d});
        diff    = wide[DW:0] - {1'b0, d};
        rem_out = q_bit ? diff : wide[DW:0];
    end

endmodule

// File: rtl/wallace_div.sv
// Sequential unsigned divider, inverse of the Wallace multiplier:
// p = q*b + r with r < b. One restoring step per cycle, MSB first.
// Divide-by-zero and quotient overflow finish in a single cycle.
module wallace_div
    import mul_div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [PW-1:0] p,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] q,
    output logic [DW-1:0] r,
    output logic          div_zero,
    output logic          ovf
);

    localparam int CW = cnt_width(DW);

    div_state_t    state;
    logic [CW-1:0] cnt;
    logic [DW:0]   rem;      // partial remainder
    logic [DW-1:0] p_lo;     // remaining dividend bits, MSB consumed first
    logic [DW-1:0] b_reg;    // divisor captured at start
    logic [DW-1:0] quo;      // quotient accumulator, bits enter at LSB

    logic [DW:0]   step_rem;
    logic          step_q;
    logic [DW-1:0] quo_nxt;

    div_step #(.DW(DW)) u_step (
        .rem_in  (rem),
        .bit_in  (p_lo[DW-1]),
        .d       (b_reg),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Quotient after the current step.
    always_comb begin
        quo_nxt = {quo[DW-2:0], step_q};
    end

    // Control FSM and datapath registers; results are held until the next
    // accepted start, and operands are captured so input changes mid-CALC
    // have no effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            p_lo     <= '0;
            b_reg    <= '0;
            quo      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            q        <= '0;
            r        <= '0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy     <= 1'b1;
                        q        <= '0;
                        r        <= '0;
                        div_zero <= 1'b0;
                        ovf      <= 1'b0;
                        b_reg    <= b;
                        p_lo     <= p[DW-1:0];
                        rem      <= {1'b0, p[PW-1:DW]};
                        quo      <= '0;
                        cnt      <= '0;
                        if (b == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            q        <= '1;
                            r        <= p[DW-1:0];
                        end else if (p[PW-1:DW] >= b) begin
                            // Upper half already >= b: quotient needs > DW bits.
                            state <= DONE;
                            done  <= 1'b1;
                            ovf   <= 1'b1;
                            q     <= '1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem  <= step_rem;
                    quo  <= quo_nxt;
                    p_lo <= {p_lo[DW-2:0], 1'b0};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(DW - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        q     <= quo_nxt;
                        r     <= step_rem[DW-1:0];
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wallace_div.sv
// Directed bench for wallace_div: reset, normal division, identities,
// divide-by-zero, overflow, reset abort and random back-to-back traffic.
module tb_wallace_div;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] p;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] q;
    logic [15:0] r;
    logic        div_zero;
    logic        ovf;

    int n_tests = 0;
    int n_fail  = 0;

    wallace_div #(.DW(16), .PW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .p        (p),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle start; returns at the negedge after the start edge.
    task automatic do_start(input logic [31:0] pv, input logic [15:0] bv);
        @(negedge clk);
        p = pv;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count cycles from the start edge until done is seen (bounded).
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        p = '0;
        b = '0;
        #12;
        n_tests++;
        if ({busy, done, div_zero, ovf} !== 4'b0) begin
            $display("FAIL reset_flags: got %b want 0000", {busy, done, div_zero, ovf});
            n_fail++;
        end
        n_tests++;
        if ({q, r} !== 32'h0) begin
            $display("FAIL reset_qr: got q=%h r=%h want 0", q, r);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        do_start(32'd200, 16'd20);
        n_tests++;
        if (busy !== 1'b1) begin
            $display("FAIL basic_busy: got %b want 1", busy);
            n_fail++;
        end
        wait_done(cyc);
        n_tests++;
        if (cyc != 17) begin
            $display("FAIL basic_latency: got %0d want 17", cyc);
            n_fail++;
        end
        n_tests++;
        if ({q, r, div_zero, ovf} !== {16'd10, 16'd0, 2'b00}) begin
            $display("FAIL basic_result: got q=%0d r=%0d dz=%b ovf=%b want 10 0 0 0", q, r, div_zero, ovf);
            n_fail++;
        end
        @(negedge clk);
        n_tests++;
        if ({done, busy} !== 2'b00) begin
            $display("FAIL basic_done_pulse: got done=%b busy=%b want 0 0", done, busy);
            n_fail++;
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if ({q, r} !== {16'd10, 16'd0}) begin
            $display("FAIL basic_hold: got q=%0d r=%0d want 10 0", q, r);
            n_fail++;
        end
    endtask

    task automatic test_div_zero();
        int cyc;
        do_start(32'd100, 16'd0);
        wait_done(cyc);
        n_tests++;
        if (cyc != 1) begin
            $display("FAIL dz_latency: got %0d want 1", cyc);
            n_fail++;
        end
        n_tests++;
        if ({q, r, div_zero, ovf} !== {16'hFFFF, 16'd100, 2'b10}) begin
            $display("FAIL dz_result: got q=%h r=%0d dz=%b ovf=%b want ffff 100 1 0", q, r, div_zero, ovf);
            n_fail++;
        end
        @(negedge clk);
        n_tests++;
        if ({done, busy} !== 2'b00) begin
            $display("FAIL dz_return: got done=%b busy=%b want 0 0", done, busy);
            n_fail++;
        end
    endtask

    task automatic test_ovf();
        int cyc;
        do_start(32'hFFFF_FFFF, 16'hFFFF);
        wait_done(cyc);
        n_tests++;
        if (cyc != 1) begin
            $display("FAIL ovf_latency: got %0d want 1", cyc);
            n_fail++;
        end
        n_tests++;
        if ({q, r, div_zero, ovf} !== {16'hFFFF, 16'd0, 2'b01}) begin
            $display("FAIL ovf_result: got q=%h r=%h dz=%b ovf=%b want ffff 0 0 1", q, r, div_zero, ovf);
            n_fail++;
        end
        @(negedge clk);
    endtask

    task automatic test_identity();
        int cyc;
        // Flags and results from the previous overflow clear at the start edge.
        do_start(32'd65535, 16'd1);
        n_tests++;
        if ({q, r, div_zero, ovf} !== 34'h0) begin
            $display("FAIL start_clear: got q=%h r=%h dz=%b ovf=%b want 0", q, r, div_zero, ovf);
            n_fail++;
        end
        wait_done(cyc);
        n_tests++;
        if ({cyc == 17, q, r} !== {1'b1, 16'd65535, 16'd0}) begin
            $display("FAIL div_by_one: got cyc=%0d q=%0d r=%0d want 17 65535 0", cyc, q, r);
            n_fail++;
        end
        @(negedge clk);
        do_start(32'd65025, 16'd255);
        wait_done(cyc);
        n_tests++;
        if ({q, r, ovf} !== {16'd255, 16'd0, 1'b0}) begin
            $display("FAIL square_255: got q=%0d r=%0d ovf=%b want 255 0 0", q, r, ovf);
            n_fail++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int cyc;
        int seen;
        do_start(32'd1000, 16'd7);
        repeat (7) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            $display("FAIL abort_busy_before: got %b want 1", busy);
            n_fail++;
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({busy, done, div_zero, ovf, q, r} !== 36'h0) begin
            $display("FAIL abort_immediate: got busy=%b done=%b dz=%b ovf=%b q=%h r=%h want all 0",
                     busy, done, div_zero, ovf, q, r);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            $display("FAIL abort_no_done: got %0d done pulses want 0", seen);
            n_fail++;
        end
        do_start(32'd1000, 16'd7);
        wait_done(cyc);
        n_tests++;
        if ({cyc == 17, q, r} !== {1'b1, 16'd142, 16'd6}) begin
            $display("FAIL abort_restart: got cyc=%0d q=%0d r=%0d want 17 142 6", cyc, q, r);
            n_fail++;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int          cyc;
        int          seen;
        logic [15:0] a;
        logic [15:0] bv;
        logic [15:0] r0;
        logic [31:0] pv;
        for (int i = 0; i < 8; i++) begin
            a  = 16'($urandom);
            bv = 16'($urandom_range(1, 65535));
            r0 = 16'($urandom_range(0, int'(bv) - 1));
            pv = 32'(a) * 32'(bv) + 32'(r0);
            do_start(pv, bv);
            // Disturb inputs and pulse start mid-calculation; both must be ignored.
            repeat (4) @(negedge clk);
            p = 32'($urandom);
            b = 16'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc = 6;
            while (done !== 1'b1 && cyc < 64) begin
                @(negedge clk);
                cyc++;
            end
            n_tests++;
            if ({cyc == 17, q, r, div_zero, ovf} !== {1'b1, a, r0, 2'b00}) begin
                $display("FAIL random_%0d: p=%h b=%h got cyc=%0d q=%h r=%h dz=%b ovf=%b want 17 q=%h r=%h",
                         i, pv, bv, cyc, q, r, div_zero, ovf, a, r0);
                n_fail++;
            end
            seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (done === 1'b1) seen++;
            end
            n_tests++;
            if ({seen, busy} !== {32'd0, 1'b0}) begin
                $display("FAIL random_single_done_%0d: got extra=%0d busy=%b want 0 0", i, seen, busy);
                n_fail++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_ovf();
        test_identity();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
